// File: rtl/mrd_rdx_stage_ctrl_if.sv
// Handshake/config bundle between the DFT sequencer, the stage controller and
// the radix/twiddle datapath. clk/rst_n stay outside as plain ports.
// master = sequencer/datapath side, slave = stage controller.
interface mrd_rdx_stage_ctrl_if #(
  parameter int wAddr = 8,
  parameter int wCnt  = 11
);
  // sequencer -> controller
  logic                  start;
  logic [2:0]            cfg_radix;
  logic [wCnt-1:0]       cfg_stride;
  logic [wCnt-1:0]       cfg_groups;
  logic [7:0]            cfg_tw_step;
  logic                  en;
  // datapath -> controller
  logic                  ret_val;
  // controller -> memory / datapath / sequencer
  logic                  rd_valid;
  logic [0:4][2:0]       rd_bank_index;
  logic [0:4][wAddr-1:0] rd_bank_addr;
  logic [2:0]            factor;
  logic [7:0]            tw_ROM_addr_step;
  logic [wCnt-1:0]       tw_ROM_exp_time;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cfg_radix, cfg_stride, cfg_groups, cfg_tw_step, en, ret_val,
    input  rd_valid, rd_bank_index, rd_bank_addr, factor, tw_ROM_addr_step,
           tw_ROM_exp_time, busy, done
  );

  modport slave (
    input  start, cfg_radix, cfg_stride, cfg_groups, cfg_tw_step, en, ret_val,
    output rd_valid, rd_bank_index, rd_bank_addr, factor, tw_ROM_addr_step,
           tw_ROM_exp_time, busy, done
  );
endinterface

// File: rtl/mrd_rdx_stage_ctrl.sv
// Sequences one radix-2/3/4/5 butterfly stage over 5 banks: issues lane reads + twiddle ctrl, counts returns.
// Latency: read request registered 1 cycle after RUN && en; PREP takes floor(S/5)+1 cycles after start.
// Backpressure: en=0 stalls issue and freezes all issue counters; returns are counted regardless.
module mrd_rdx_stage_ctrl #(
  parameter int wAddr = 8,
  parameter int wCnt  = 11,
  parameter int NBANK = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mrd_rdx_stage_ctrl_if.slave bus
);

  localparam int                wIss     = 2 * wCnt;
  localparam logic [2:0]        NB       = 3'(NBANK);
  localparam logic [wCnt-1:0]   NB_CNT   = wCnt'(NBANK);
  localparam logic [wCnt-1:0]   ONE_CNT  = wCnt'(1);
  localparam logic [wAddr-1:0]  ONE_ADDR = wAddr'(1);
  localparam logic [wIss-1:0]   ONE_ISS  = wIss'(1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [2:0]            radix_q, radix_d;
  logic [wCnt-1:0]       stride_q, stride_d;
  logic [wCnt-1:0]       groups_q, groups_d;
  logic [7:0]            tw_step_q, tw_step_d;
  // Stride split as (Sq, Sr) = (S div 5, S mod 5), built by repeated subtraction in PREP
  logic [wAddr-1:0]      sq_q, sq_d;
  logic [wCnt-1:0]       sr_q, sr_d;
  // Lane-0 point of the current butterfly as (quotient, remainder)
  logic [wAddr-1:0]      bq_q, bq_d;
  logic [2:0]            br_q, br_d;
  logic [wCnt-1:0]       i_q, i_d;
  logic [wCnt-1:0]       g_q, g_d;
  logic [wIss-1:0]       iss_cnt_q, iss_cnt_d;
  logic [wIss-1:0]       ret_cnt_q, ret_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [0:4][2:0]       bank_q, bank_d;
  logic [0:4][wAddr-1:0] addr_q, addr_d;
  logic [wCnt-1:0]       exp_time_q, exp_time_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [0:4][wAddr-1:0] lane_quo;
  logic [0:4][2:0]       lane_rem;
  logic [wAddr-1:0]      last_quo;
  logic [2:0]            last_rem;
  logic                  issue;
  logic                  last_i;
  logic                  last_bfly;

  assign issue     = (state_q == RUN) && bus.en;
  assign last_i    = (i_q == stride_q - ONE_CNT);
  assign last_bfly = last_i && (g_q == groups_q - ONE_CNT);

  // Lane j = lane j-1 + (Sq, Sr); remainders stay in 0..4 so one conditional subtract suffices
  always_comb begin
    lane_quo    = '0;
    lane_rem    = '0;
    lane_quo[0] = bq_q;
    lane_rem[0] = br_q;
    for (int j = 1; j < 5; j++) begin
      if (lane_rem[j-1] >= (NB - sr_q[2:0])) begin
        lane_rem[j] = lane_rem[j-1] - (NB - sr_q[2:0]);
        lane_quo[j] = lane_quo[j-1] + sq_q + ONE_ADDR;
      end else begin
        lane_rem[j] = lane_rem[j-1] + sr_q[2:0];
        lane_quo[j] = lane_quo[j-1] + sq_q;
      end
    end
  end

  // Pick lane r-1; the next group's base is that point plus one
  always_comb begin
    last_quo = lane_quo[4];
    last_rem = lane_rem[4];
    case (radix_q)
      3'd2:    begin last_quo = lane_quo[1]; last_rem = lane_rem[1]; end
      3'd3:    begin last_quo = lane_quo[2]; last_rem = lane_rem[2]; end
      3'd4:    begin last_quo = lane_quo[3]; last_rem = lane_rem[3]; end
      default: begin last_quo = lane_quo[4]; last_rem = lane_rem[4]; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    if (sr_q < NB_CNT) state_d = RUN;
      RUN:     if (issue && last_bfly) state_d = DRAIN;
      DRAIN:   if (ret_cnt_q == iss_cnt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values: config latch, stride split, butterfly walk, issue and return counts
  always_comb begin
    radix_d    = radix_q;
    stride_d   = stride_q;
    groups_d   = groups_q;
    tw_step_d  = tw_step_q;
    sq_d       = sq_q;
    sr_d       = sr_q;
    bq_d       = bq_q;
    br_d       = br_q;
    i_d        = i_q;
    g_d        = g_q;
    iss_cnt_d  = iss_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    exp_time_d = exp_time_q;
    busy_d     = busy_q;
    rd_valid_d = issue;
    done_d     = 1'b0;

    // Returns may overlap issue, including the RUN->DRAIN cycle
    if ((state_q != IDLE) && bus.ret_val) ret_cnt_d = ret_cnt_q + ONE_ISS;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          radix_d   = bus.cfg_radix;
          stride_d  = bus.cfg_stride;
          groups_d  = bus.cfg_groups;
          tw_step_d = bus.cfg_tw_step;
          sq_d      = '0;
          sr_d      = bus.cfg_stride;
          iss_cnt_d = '0;
          ret_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      PREP: begin
        if (sr_q >= NB_CNT) begin
          sr_d = sr_q - NB_CNT;
          sq_d = sq_q + ONE_ADDR;
        end else begin
          bq_d = '0;
          br_d = '0;
          i_d  = '0;
          g_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          for (int j = 0; j < 5; j++) begin
            if (3'(j) < radix_q) begin
              bank_d[j] = lane_rem[j];
              addr_d[j] = lane_quo[j];
            end else begin
              bank_d[j] = '0;
              addr_d[j] = '0;
            end
          end
          exp_time_d = i_q;
          iss_cnt_d  = iss_cnt_q + ONE_ISS;
          if (!last_i) begin
            i_d = i_q + ONE_CNT;
            if (br_q == NB - 3'd1) begin
              bq_d = bq_q + ONE_ADDR;
              br_d = '0;
            end else begin
              br_d = br_q + 3'd1;
            end
          end else begin
            i_d = '0;
            g_d = g_q + ONE_CNT;
            if (last_rem == NB - 3'd1) begin
              bq_d = last_quo + ONE_ADDR;
              br_d = '0;
            end else begin
              bq_d = last_quo;
              br_d = last_rem + 3'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (ret_cnt_q == iss_cnt_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath/output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radix_q    <= '0;
      stride_q   <= '0;
      groups_q   <= '0;
      tw_step_q  <= '0;
      sq_q       <= '0;
      sr_q       <= '0;
      bq_q       <= '0;
      br_q       <= '0;
      i_q        <= '0;
      g_q        <= '0;
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      bank_q     <= '0;
      addr_q     <= '0;
      exp_time_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      radix_q    <= radix_d;
      stride_q   <= stride_d;
      groups_q   <= groups_d;
      tw_step_q  <= tw_step_d;
      sq_q       <= sq_d;
      sr_q       <= sr_d;
      bq_q       <= bq_d;
      br_q       <= br_d;
      i_q        <= i_d;
      g_q        <= g_d;
      iss_cnt_q  <= iss_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      rd_valid_q <= rd_valid_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      exp_time_q <= exp_time_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rd_valid         = rd_valid_q;
  assign bus.rd_bank_index    = bank_q;
  assign bus.rd_bank_addr     = addr_q;
  assign bus.factor           = radix_q;
  assign bus.tw_ROM_addr_step = tw_step_q;
  assign bus.tw_ROM_exp_time  = exp_time_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_mrd_rdx_stage_ctrl.sv
// Bench for mrd_rdx_stage_ctrl: table of stage configs with expected issue count and PREP length,
// a reference point-address model feeding a scoreboard queue, plus hand sequences for reset and timing.
module tb_mrd_rdx_stage_ctrl;
  localparam int WA = 8;
  localparam int WC = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mrd_rdx_stage_ctrl_if #(.wAddr(WA), .wCnt(WC)) bus ();
  mrd_rdx_stage_ctrl #(.wAddr(WA), .wCnt(WC), .NBANK(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [0:4][2:0]    bank;
    logic [0:4][WA-1:0] addr;
    int                 t;
  } exp_t;

  typedef struct {
    int       radix;
    int       stride;
    int       groups;
    int       tw;
    logic [3:0] en_pat;
    int       dly;
    bit       lockstep;
    bit       restart;
    bit       uniq;
    int       exp_issues;
    int       exp_prep;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   ret_q[$];
  int   n_obs, first_rv, done_cnt, done_cyc, stall_viol, busy_viol;
  int   p0, dly, cur_radix, dup_cnt, mark_cnt;
  bit   busy_chk, lockstep, uniq_en;
  bit   seen [0:1279];
  logic [0:4][2:0]    obs_bank [0:255];
  logic [0:4][WA-1:0] obs_addr [0:255];
  int                 obs_t    [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference addressing: direct multiply/divide of the point index
  task automatic build_exp(input vec_t v);
    exp_t e;
    int   base;
    int   p;
    exp_q.delete();
    for (int g = 0; g < v.groups; g++) begin
      for (int i = 0; i < v.stride; i++) begin
        base   = g * v.stride * v.radix + i;
        e.bank = '0;
        e.addr = '0;
        e.t    = i;
        for (int j = 0; j < 5; j++) begin
          if (j < v.radix) begin
            p         = base + j * v.stride;
            e.bank[j] = 3'(p % 5);
            e.addr[j] = WA'(p / 5);
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_obs(input vec_t v);
    ret_q.delete();
    n_obs = 0; first_rv = -1; done_cnt = 0; done_cyc = -1;
    stall_viol = 0; busy_viol = 0; dup_cnt = 0; mark_cnt = 0;
    dly = v.dly; lockstep = v.lockstep; uniq_en = v.uniq; cur_radix = v.radix;
    for (int k = 0; k < 1280; k++) seen[k] = 1'b0;
  endtask

  // Monitor: scoreboard pop on every read request, return scheduling, done/busy/stall tracking
  initial begin : mon
    logic en_s;
    exp_t e;
    int   idx;
    en_s = 1'b0;
    forever begin
      @(posedge clk);
      en_s = bus.en;
      @(negedge clk);
      if (rst_n) begin
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy_chk && done_cnt == 0 && cyc >= p0 && !bus.busy) busy_viol++;
        if (bus.rd_valid) begin
          if (!en_s) stall_viol++;
          if (n_obs == 0) first_rv = cyc;
          if (n_obs < 256) begin
            obs_bank[n_obs] = bus.rd_bank_index;
            obs_addr[n_obs] = bus.rd_bank_addr;
            obs_t[n_obs]    = int'(bus.tw_ROM_exp_time);
          end
          chk($sformatf("exp_avail[%0d]", n_obs), 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("bank[%0d]", n_obs), 64'(bus.rd_bank_index), 64'(e.bank));
            chk($sformatf("addr[%0d]", n_obs), 64'(bus.rd_bank_addr), 64'(e.addr));
            chk($sformatf("exp_time[%0d]", n_obs), 64'(bus.tw_ROM_exp_time), 64'(e.t));
          end
          if (!lockstep) ret_q.push_back(cyc + dly);
          if (uniq_en) begin
            for (int j = 0; j < 5; j++) begin
              if (j < cur_radix) begin
                idx = int'(bus.rd_bank_index[j]) * 256 + int'(bus.rd_bank_addr[j]);
                if (seen[idx]) dup_cnt++;
                else begin seen[idx] = 1'b1; mark_cnt++; end
              end
            end
          end
          n_obs++;
        end
      end
    end
  end

  task automatic run_case(input int id, input vec_t v);
    int ret_sent, last_drive, tmo;
    clear_obs(v);
    build_exp(v);
    ret_sent = 0; last_drive = -100; tmo = 0;
    @(posedge clk); #1;
    bus.cfg_radix   = 3'(v.radix);
    bus.cfg_stride  = WC'(v.stride);
    bus.cfg_groups  = WC'(v.groups);
    bus.cfg_tw_step = 8'(v.tw);
    bus.en          = 1'b1;
    bus.start       = 1'b1;
    p0       = cyc + 1;
    busy_chk = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.cfg_radix   = 3'd7;
    bus.cfg_stride  = '0;
    bus.cfg_groups  = '0;
    bus.cfg_tw_step = 8'hff;
    while (done_cnt == 0 && tmo < 6000) begin
      if (cyc >= p0 + v.exp_prep) bus.en = v.en_pat[(cyc - p0 - v.exp_prep) % 4];
      else                        bus.en = 1'b1;
      if (v.lockstep) begin
        bus.ret_val = (cyc >= p0 + v.exp_prep) && (cyc < p0 + v.exp_prep + v.exp_issues);
      end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
        void'(ret_q.pop_front());
        bus.ret_val = 1'b1;
      end else begin
        bus.ret_val = 1'b0;
      end
      if (bus.ret_val) begin ret_sent++; last_drive = cyc; end
      bus.start = v.restart && (cyc == p0 + v.exp_prep + 3);
      @(posedge clk); #1;
      tmo++;
    end
    bus.ret_val = 1'b0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    busy_chk = 1'b0;
    chk($sformatf("c%0d_done_pulses", id), 64'(done_cnt), 64'd1);
    chk($sformatf("c%0d_done_timing", id), 64'(done_cyc), 64'(last_drive + 2));
    chk($sformatf("c%0d_issues", id), 64'(n_obs), 64'(v.exp_issues));
    chk($sformatf("c%0d_exp_left", id), 64'(exp_q.size()), 64'd0);
    chk($sformatf("c%0d_rets", id), 64'(ret_sent), 64'(v.exp_issues));
    chk($sformatf("c%0d_first_rv", id), 64'(first_rv), 64'(p0 + v.exp_prep + 1));
    chk($sformatf("c%0d_stall_issue", id), 64'(stall_viol), 64'd0);
    chk($sformatf("c%0d_busy_gap", id), 64'(busy_viol), 64'd0);
    chk($sformatf("c%0d_busy_end", id), 64'(bus.busy), 64'd0);
    chk($sformatf("c%0d_factor", id), 64'(bus.factor), 64'(v.radix));
    chk($sformatf("c%0d_tw_step", id), 64'(bus.tw_ROM_addr_step), 64'(v.tw));
  endtask

  initial begin : main
    vec_t vecs [6];
    logic [0:4][2:0]    xb;
    logic [0:4][WA-1:0] xa;
    int   ts [6];
    int   tmo;

    vecs[0] = '{radix:4, stride:3,  groups:2,  tw:7,   en_pat:4'b1111, dly:3, lockstep:0, restart:0, uniq:0, exp_issues:6,   exp_prep:1};
    vecs[1] = '{radix:5, stride:12, groups:20, tw:9,   en_pat:4'b1111, dly:2, lockstep:0, restart:0, uniq:1, exp_issues:240, exp_prep:3};
    vecs[2] = '{radix:2, stride:1,  groups:6,  tw:3,   en_pat:4'b0101, dly:1, lockstep:0, restart:0, uniq:0, exp_issues:6,   exp_prep:1};
    vecs[3] = '{radix:2, stride:5,  groups:2,  tw:5,   en_pat:4'b1111, dly:7, lockstep:0, restart:1, uniq:0, exp_issues:10,  exp_prep:2};
    vecs[4] = '{radix:3, stride:7,  groups:3,  tw:200, en_pat:4'b1011, dly:4, lockstep:0, restart:0, uniq:0, exp_issues:21,  exp_prep:2};
    vecs[5] = '{radix:2, stride:1,  groups:4,  tw:1,   en_pat:4'b1111, dly:0, lockstep:1, restart:0, uniq:0, exp_issues:4,   exp_prep:1};
    ts = '{0, 1, 2, 0, 1, 2};

    bus.start = 1'b0; bus.cfg_radix = '0; bus.cfg_stride = '0; bus.cfg_groups = '0;
    bus.cfg_tw_step = '0; bus.en = 1'b0; bus.ret_val = 1'b0;
    busy_chk = 1'b0; lockstep = 1'b0; uniq_en = 1'b0; p0 = 0; dly = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_factor", 64'(bus.factor), 64'd0);
    chk("rst_tw_step", 64'(bus.tw_ROM_addr_step), 64'd0);
    chk("rst_exp_time", 64'(bus.tw_ROM_exp_time), 64'd0);
    chk("rst_bank", 64'(bus.rd_bank_index), 64'd0);
    chk("rst_addr", 64'(bus.rd_bank_addr), 64'd0);
    rst_n = 1'b1;

    // Reset asserted mid-RUN
    clear_obs(vecs[0]);
    build_exp(vecs[0]);
    @(posedge clk); #1;
    bus.cfg_radix = 3'd4; bus.cfg_stride = WC'(3); bus.cfg_groups = WC'(2); bus.cfg_tw_step = 8'd7;
    bus.en = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tmo = 0;
    while (n_obs < 2 && tmo < 50) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("rst_pre_issues", 64'(n_obs >= 2), 64'd1);
    #2;
    chk("rst_pre_rd_valid", 64'(bus.rd_valid), 64'd1);
    chk("rst_pre_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_factor", 64'(bus.factor), 64'd0);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_done", 64'(bus.done), 64'd0);
    chk("rst_no_done_pulse", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;

    // Table-driven stage runs
    for (int k = 0; k < 6; k++) begin
      run_case(k, vecs[k]);
      if (k == 0) begin
        xb = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd0}; xa = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
        chk("r4_bfly0_bank", 64'(obs_bank[0]), 64'(xb));
        chk("r4_bfly0_addr", 64'(obs_addr[0]), 64'(xa));
        xb = '{3'd1, 3'd4, 3'd2, 3'd0, 3'd0}; xa = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd0};
        chk("r4_bfly1_bank", 64'(obs_bank[1]), 64'(xb));
        chk("r4_bfly1_addr", 64'(obs_addr[1]), 64'(xa));
        xb = '{3'd2, 3'd0, 3'd3, 3'd1, 3'd0}; xa = '{8'd2, 8'd3, 8'd3, 8'd4, 8'd0};
        chk("r4_bfly3_bank", 64'(obs_bank[3]), 64'(xb));
        chk("r4_bfly3_addr", 64'(obs_addr[3]), 64'(xa));
        for (int n = 0; n < 6; n++) chk($sformatf("r4_exp_time[%0d]", n), 64'(obs_t[n]), 64'(ts[n]));
      end
      if (k == 1) begin
        chk("r5_last_lane4_bank", 64'(obs_bank[239][4]), 64'd4);
        chk("r5_last_lane4_addr", 64'(obs_addr[239][4]), 64'd239);
        chk("r5_unique_points", 64'(mark_cnt), 64'd1200);
        chk("r5_duplicates", 64'(dup_cnt), 64'd0);
      end
      if (k == 2) begin
        for (int n = 0; n < 6; n++) begin
          chk($sformatf("r2_hi_lanes_bank[%0d]", n), 64'({obs_bank[n][2], obs_bank[n][3], obs_bank[n][4]}), 64'd0);
          chk($sformatf("r2_hi_lanes_addr[%0d]", n), 64'({obs_addr[n][2], obs_addr[n][3], obs_addr[n][4]}), 64'd0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
